mod_updown_counter: RTL and testbench

Parametrised up/down counter and successor to the team's fixed 8-bit free-running counter. Adds configurable width and modulus, enable with clock-prescaling, direction control, parallel load, wrap or saturate mode, and terminal-count status. Intended as the general timing and event counter in the datapath, driven from the single system clock.

---
 rtl/mod_updown_counter.sv | 108 ++++++++++
 tb/tb_mod_updown_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with prescaler, parallel load, wrap/saturate and terminal count.
// Optional sticky wrap flag (wrapped / wrap_clr ports) is built when COUNTER_WRAP_FLAG_EN is defined.
module mod_updown_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
`ifdef COUNTER_WRAP_FLAG_EN
    ,
    output logic             wrapped,
    input  logic             wrap_clr
`endif
);

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
    localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};

    logic [PW-1:0]    pre_r;
    logic             tick_s;
    logic [WIDTH-1:0] next_count_s;
    logic             next_tc_s;

    assign tick_s  = en && (pre_r == PRE_LAST);
    assign at_max  = (count == MAX_V);
    assign at_zero = (count == ZERO_V);

    // Next count and terminal-count decision: load beats a tick, boundary ticks wrap or hold
    always_comb begin
        next_count_s = count;
        next_tc_s    = 1'b0;
        if (load) begin
            next_count_s = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick_s) begin
            if (up) begin
                if (count >= MAX_V) begin
                    next_tc_s    = 1'b1;
                    next_count_s = SATURATE ? MAX_V : ZERO_V;
                end else begin
                    next_count_s = count + WIDTH'(1);
                end
            end else begin
                if (count == ZERO_V) begin
                    next_tc_s    = 1'b1;
                    next_count_s = SATURATE ? ZERO_V : MAX_V;
                end else begin
                    next_count_s = count - WIDTH'(1);
                end
            end
        end else begin
            next_count_s = count;
        end
    end

    // Count, terminal-count pulse and prescaler registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= ZERO_V;
            tc    <= 1'b0;
            pre_r <= PRE_ZERO;
        end else begin
            count <= next_count_s;
            tc    <= next_tc_s;
            if (load || tick_s) begin
                pre_r <= PRE_ZERO;
            end else if (en) begin
                pre_r <= pre_r + PW'(1);
            end else begin
                pre_r <= pre_r;
            end
        end
    end

`ifdef COUNTER_WRAP_FLAG_EN
    logic wrap_s;

    // A wrap is a non-load boundary tick in wrap mode; saturating counters never wrap
    assign wrap_s = !SATURATE && !load && tick_s &&
                    ((up && (count >= MAX_V)) || (!up && (count == ZERO_V)));

    // Sticky wrap flag: a new wrap beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            wrapped <= 1'b0;
        end else if (wrap_s) begin
            wrapped <= 1'b1;
        end else if (wrap_clr) begin
            wrapped <= 1'b0;
        end else begin
            wrapped <= wrapped;
        end
    end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: four instances (default, modulus 9, saturate,
// prescale 4) share one stimulus; each directed vector names the instance it checks.
module tb_mod_updown_counter;

    localparam int NDUT = 4;
    localparam int MAXT [NDUT] = '{255, 9, 255, 255};
    localparam int PRET [NDUT] = '{1, 1, 1, 4};
    localparam bit SATT [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       wrap_clr = 1'b0;

    logic [7:0] cnt   [NDUT];
    logic       tcv   [NDUT];
    logic       amax  [NDUT];
    logic       azero [NDUT];
    logic       wr    [NDUT];

    typedef struct {
        int         sel;
        logic [7:0] c;
        logic       t;
        logic       w;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mod_updown_counter #(
            .WIDTH(8),
            .MAX_VAL(MAXT[g]),
            .PRESCALE(PRET[g]),
            .SATURATE(SATT[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .en(en),
            .up(up),
            .load(load),
            .load_val(load_val),
            .count(cnt[g]),
            .tc(tcv[g]),
            .at_max(amax[g]),
            .at_zero(azero[g])
`ifdef COUNTER_WRAP_FLAG_EN
            ,
            .wrapped(wr[g]),
            .wrap_clr(wrap_clr)
`endif
        );
`ifndef COUNTER_WRAP_FLAG_EN
        assign wr[g] = 1'b0;
`endif
    end

    // Monitor: every edge that follows a stimulus step is checked against the queued expectation
    always @(posedge clk) begin
        exp_t e;
        logic exp_max;
        logic exp_zero;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_max  = (int'(e.c) == MAXT[e.sel]) ? 1'b1 : 1'b0;
            exp_zero = (e.c == 8'd0) ? 1'b1 : 1'b0;
            tests++;
            if (cnt[e.sel] !== e.c) begin
                failed++;
                $display("FAIL count dut%0d: got %0d, expected %0d (t=%0t)", e.sel, cnt[e.sel], e.c, $time);
            end
            tests++;
            if (tcv[e.sel] !== e.t) begin
                failed++;
                $display("FAIL tc dut%0d: got %0d, expected %0d (t=%0t)", e.sel, tcv[e.sel], e.t, $time);
            end
            tests++;
            if (amax[e.sel] !== exp_max) begin
                failed++;
                $display("FAIL at_max dut%0d: got %0d, expected %0d (t=%0t)", e.sel, amax[e.sel], exp_max, $time);
            end
            tests++;
            if (azero[e.sel] !== exp_zero) begin
                failed++;
                $display("FAIL at_zero dut%0d: got %0d, expected %0d (t=%0t)", e.sel, azero[e.sel], exp_zero, $time);
            end
`ifdef COUNTER_WRAP_FLAG_EN
            if (e.sel == 0 || e.sel == 2) begin
                tests++;
                if (wr[e.sel] !== e.w) begin
                    failed++;
                    $display("FAIL wrapped dut%0d: got %0d, expected %0d (t=%0t)", e.sel, wr[e.sel], e.w, $time);
                end
            end
`endif
        end
    end

    // One clock of stimulus plus the state the selected instance must show after the next edge
    task automatic step(input logic r_i, input logic e_i, input logic u_i, input logic l_i,
                        input logic [7:0] lv_i, input logic wc_i, input int sel_i,
                        input logic [7:0] c_i, input logic t_i, input logic w_i);
        exp_t e;
        @(negedge clk);
        rst      = r_i;
        en       = e_i;
        up       = u_i;
        load     = l_i;
        load_val = lv_i;
        wrap_clr = wc_i;
        e.sel = sel_i;
        e.c   = c_i;
        e.t   = t_i;
        e.w   = w_i;
        q.push_back(e);
    endtask

    initial begin
        // Reset then free run up on the default instance
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 0, 8'(i), 1'b0, 1'b0);

        // Wrap up at 255, sticky flag, clear
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd0,   1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd254, 1'b0, 0, 8'd254, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd255, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd0,   1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd0,   1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 0, 8'd0,   1'b0, 1'b0);
        // Wrap down at 0 coinciding with a clear: set wins
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 0, 8'd255, 1'b1, 1'b1);

        // Modulus 9: down wrap, up wrap, clamped load
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd1,   1'b0, 1, 8'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1, 8'd9, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1, 8'd8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 1'b0, 1, 8'd9, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1, 8'd0, 1'b1, 1'b0);

        // Saturate: hold at both boundaries with tc on every boundary tick
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 2, 8'd0,   1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd253, 1'b0, 2, 8'd253, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 2, 8'd254, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 2, 8'd255, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2, 8'd255, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 2, 8'd0,   1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 2, 8'd0,   1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 2, 8'd1,   1'b0, 1'b0);

        // Prescale 4: steps after enabled cycles 4, 8, 12
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'(i / 4), 1'b0, 1'b0);
        // en low holds the prescaler; three more enabled cycles are needed after two
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd1, 1'b0, 1'b0);
        // Reset after six enabled cycles clears the prescaler
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, (i >= 4) ? 8'd1 : 8'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, (i == 4) ? 8'd1 : 8'd0, 1'b0, 1'b0);
        // Load on a tick cycle restarts the prescaler
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, 8'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 3, 8'd5, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 3, (i == 4) ? 8'd6 : 8'd5, 1'b0, 1'b0);

        // Priority: load beats a boundary tick, reset beats load, direction change
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd0,   1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd255, 1'b0, 0, 8'd255, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd7,   1'b0, 0, 8'd7,   1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd8,   1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 0, 8'd7,   1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'd7,   1'b0, 0, 8'd0,   1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 8'd0,   1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        #5;
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
